// File: rtl/pi_frame_rx.sv
// Framed byte receiver for the Pi GPIO bus: SYNC/LEN/payload/CHK parser
// feeding a show-ahead FIFO whose payload stays hidden until the checksum commits.
module pi_frame_rx #(
    parameter int         DEPTH   = 32,
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SYNC    = 8'hA5,
    parameter int         TIMEOUT = 1024
) (
    input  logic                     pi_clk,
    input  logic                     rst_n,
    input  logic [7:0]               gpio_data,
    input  logic                     gpio_valid,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [1:0]               err_cause,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GETLEN,
        PAYLOAD,
        GETCHK,
        DISCARD
    } state_t;

    state_t        state;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   cm_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    chk;
    logic [8:0]    cnt;
    logic [TW-1:0] idle;
    logic [7:0]    mem [DEPTH];

    logic          pop;
    logic [AW:0]   free;
    logic          len_bad;
    logic          len_ovf;

    // Only committed bytes count toward level; speculative ones sit past cm_ptr.
    assign level     = cm_ptr - rd_ptr;
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign pop       = out_valid & out_ready;
    assign busy      = (state != IDLE);
    assign free      = (AW+1)'(DEPTH) - level;
    assign len_bad   = (gpio_data == 8'd0) || (gpio_data > 8'(MAX_LEN));
    assign len_ovf   = 32'(gpio_data) > 32'(free);

    always_ff @(posedge pi_clk) begin
        if (!rst_n && state == PAYLOAD && gpio_valid)
            mem[wr_ptr[AW-1:0]] <= gpio_data;
    end

    always_ff @(posedge pi_clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            cm_ptr    <= '0;
            rd_ptr    <= '0;
            chk       <= '0;
            cnt       <= '0;
            idle      <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_cause <= 2'd0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (gpio_valid) begin
                idle <= '0;
                unique case (state)
                    IDLE: begin
                        if (gpio_data == SYNC)
                            state <= GETLEN;
                    end
                    GETLEN: begin
                        chk <= gpio_data;
                        cnt <= {1'b0, gpio_data};
                        if (len_bad) begin
                            frame_err <= 1'b1;
                            err_cause <= 2'd1;
                            state     <= IDLE;
                        end else if (len_ovf) begin
                            frame_err <= 1'b1;
                            err_cause <= 2'd2;
                            cnt       <= {1'b0, gpio_data} + 9'd1;
                            state     <= DISCARD;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        chk    <= chk ^ gpio_data;
                        cnt    <= cnt - 9'd1;
                        if (cnt == 9'd1)
                            state <= GETCHK;
                    end
                    GETCHK: begin
                        if (gpio_data == chk) begin
                            cm_ptr   <= wr_ptr;
                            frame_ok <= 1'b1;
                        end else begin
                            wr_ptr    <= cm_ptr;
                            frame_err <= 1'b1;
                            err_cause <= 2'd0;
                        end
                        state <= IDLE;
                    end
                    DISCARD: begin
                        cnt <= cnt - 9'd1;
                        if (cnt == 9'd1)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (idle == TW'(TIMEOUT - 1)) begin
                    wr_ptr    <= cm_ptr;
                    frame_err <= 1'b1;
                    err_cause <= 2'd3;
                    idle      <= '0;
                    state     <= IDLE;
                end else begin
                    idle <= idle + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pi_frame_rx.sv
// Bench for pi_frame_rx: queue-based frame model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pi_frame_rx;

    localparam int DEPTH   = 32;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 1024;
    localparam bit [7:0] SYNC = 8'hA5;

    logic       pi_clk = 1'b0;
    logic       rst_n  = 1'b1;
    logic [7:0] gpio_data = 8'h00;
    logic       gpio_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [5:0] level;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_cause;
    logic       busy;

    pi_frame_rx #(
        .DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .pi_clk(pi_clk), .rst_n(rst_n),
        .gpio_data(gpio_data), .gpio_valid(gpio_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .frame_ok(frame_ok), .frame_err(frame_err),
        .err_cause(err_cause), .busy(busy)
    );

    always #5 pi_clk = ~pi_clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: committed bytes as a queue, current frame as a byte list.
    bit [7:0] q[$];
    bit [7:0] fr[$];
    bit [7:0] add[$];
    bit [7:0] dut_pops[$];
    bit       in_frame = 0;
    int       disc = 0;
    int       idle = 0;
    bit       m_ok = 0;
    bit       m_err = 0;
    bit [1:0] m_cause = 0;
    int       sz0;
    bit       popit;
    int       flen;
    bit [7:0] x;

    task automatic drop(input bit [1:0] c);
        m_err   = 1;
        m_cause = c;
        in_frame = 0;
    endtask

    always @(posedge pi_clk or posedge rst_n) begin
        if (rst_n) begin
            q.delete(); fr.delete(); add.delete();
            in_frame = 0; disc = 0; idle = 0;
            m_ok = 0; m_err = 0; m_cause = 0;
        end else begin
            sz0   = q.size();
            popit = (sz0 > 0) && out_ready;
            if (out_valid && out_ready)
                dut_pops.push_back(out_data);
            m_ok = 0;
            m_err = 0;
            add.delete();
            if (gpio_valid) begin
                idle = 0;
                if (disc > 0) begin
                    disc--;
                end else if (!in_frame) begin
                    if (gpio_data == SYNC) begin
                        in_frame = 1;
                        fr.delete();
                    end
                end else begin
                    fr.push_back(gpio_data);
                    flen = fr[0];
                    if (fr.size() == 1) begin
                        if (flen == 0 || flen > MAX_LEN)
                            drop(1);
                        else if (flen > DEPTH - sz0) begin
                            drop(2);
                            disc = flen + 1;
                        end
                    end else if (fr.size() == flen + 2) begin
                        x = 0;
                        for (int i = 0; i <= flen; i++) x ^= fr[i];
                        if (x == fr[flen+1]) begin
                            for (int i = 1; i <= flen; i++) add.push_back(fr[i]);
                            m_ok = 1;
                            in_frame = 0;
                        end else begin
                            drop(0);
                        end
                    end
                end
            end else if (in_frame || disc > 0) begin
                idle++;
                if (idle == TIMEOUT) begin
                    drop(3);
                    disc = 0;
                    idle = 0;
                end
            end
            if (popit) void'(q.pop_front());
            foreach (add[i]) q.push_back(add[i]);
        end
    end

    int ok_cnt = 0;
    int err_cnt = 0;

    always @(negedge pi_clk) begin
        if (!rst_n) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("out_data", out_data, q.size() > 0 ? q[0] : 8'h00);
            chk("level", level, q.size());
            chk("frame_ok", frame_ok, m_ok);
            chk("frame_err", frame_err, m_err);
            chk("err_cause", err_cause, m_cause);
            chk("busy", busy, in_frame || disc > 0);
            if (frame_ok) ok_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    bit rand_ready = 0;

    task automatic cyc(input bit v, input bit [7:0] d);
        @(negedge pi_clk);
        gpio_valid = v;
        gpio_data  = v ? d : 8'($urandom);
        if (rand_ready) out_ready = $urandom_range(0, 1) == 1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    task automatic send_frame(input int len, input bit bad, input int gap);
        bit [7:0] c;
        bit [7:0] b;
        c = 8'(len);
        cyc(1, SYNC);
        if (gap > 0) idle_n($urandom_range(0, gap));
        cyc(1, 8'(len));
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            c ^= b;
            if (gap > 0) idle_n($urandom_range(0, gap));
            cyc(1, b);
        end
        cyc(1, bad ? ~c : c);
    endtask

    int e0;
    int o0;
    int r;

    initial begin
        // Reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cause", err_cause, 0);
        @(negedge pi_clk);
        rst_n = 1'b0;

        // Good frame
        out_ready = 1;
        dut_pops.delete();
        o0 = ok_cnt;
        cyc(1, 8'hA5); cyc(1, 8'h03); cyc(1, 8'h01);
        cyc(1, 8'h02); cyc(1, 8'h03); cyc(1, 8'h03);
        idle_n(6);
        chk("good_ok_cnt", ok_cnt - o0, 1);
        chk("good_npops", dut_pops.size(), 3);
        if (dut_pops.size() == 3) begin
            chk("good_b0", dut_pops[0], 8'h01);
            chk("good_b1", dut_pops[1], 8'h02);
            chk("good_b2", dut_pops[2], 8'h03);
        end
        chk("good_level", level, 0);

        // Checksum error then good frame
        dut_pops.delete();
        e0 = err_cnt;
        cyc(1, 8'hA5); cyc(1, 8'h02); cyc(1, 8'h10);
        cyc(1, 8'h20); cyc(1, 8'h00);
        cyc(0, 0);
        chk("chk_err_pulse", frame_err, 1);
        chk("chk_cause", err_cause, 0);
        chk("chk_novalid", out_valid, 0);
        cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'h77); cyc(1, 8'h76);
        idle_n(4);
        chk("chk_after_npops", dut_pops.size(), 1);
        if (dut_pops.size() == 1) chk("chk_after_b", dut_pops[0], 8'h77);

        // Length errors
        cyc(1, 8'hA5); cyc(1, 8'h00);
        cyc(0, 0);
        chk("len0_cause", err_cause, 1);
        chk("len0_busy", busy, 0);
        cyc(1, 8'hA5); cyc(1, 8'h04); cyc(1, 8'h01); cyc(1, 8'h02);
        cyc(1, 8'h03); cyc(1, 8'h04); cyc(1, 8'h00);
        cyc(0, 0);
        chk("ok_cause_held", err_cause, 1);
        cyc(1, 8'hA5); cyc(1, 8'h11);
        cyc(0, 0);
        chk("len17_err", frame_err, 1);
        chk("len17_cause", err_cause, 1);
        chk("len17_busy", busy, 0);
        idle_n(8);

        // Overflow: fill to exactly DEPTH, third frame must be discarded
        out_ready = 0;
        send_frame(16, 0, 0);
        send_frame(16, 0, 0);
        cyc(0, 0);
        chk("full_level", level, 32);
        cyc(1, 8'hA5); cyc(1, 8'h01);
        cyc(0, 0);
        chk("ovf_cause", err_cause, 2);
        chk("ovf_busy", busy, 1);
        cyc(1, 8'hA5); cyc(1, 8'h00);
        cyc(0, 0);
        chk("ovf_done_busy", busy, 0);
        chk("ovf_level", level, 32);
        dut_pops.delete();
        out_ready = 1;
        cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'h55); cyc(1, 8'h54);
        idle_n(40);
        chk("ovf_npops", dut_pops.size(), 33);
        if (dut_pops.size() == 33) chk("ovf_tail", dut_pops[32], 8'h55);

        // Commit and pop on the same edge
        out_ready = 0;
        send_frame(2, 0, 0);
        cyc(1, 8'hA5); cyc(1, 8'h03); cyc(1, 8'h10); cyc(1, 8'h20); cyc(1, 8'h30);
        cyc(1, 8'h03 ^ 8'h10 ^ 8'h20 ^ 8'h30);
        out_ready = 1;
        cyc(0, 0);
        out_ready = 0;
        chk("simul_level", level, 4);
        chk("simul_ok", frame_ok, 1);
        out_ready = 1;
        idle_n(8);

        // Timeout with one committed byte waiting
        out_ready = 0;
        cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'h5A); cyc(1, 8'h5B);
        cyc(1, 8'hA5); cyc(1, 8'h04); cyc(1, 8'hAA);
        e0 = err_cnt;
        idle_n(TIMEOUT);
        chk("tmo_not_early", err_cnt - e0, 0);
        chk("tmo_busy_before", busy, 1);
        cyc(0, 0);
        chk("tmo_err", frame_err, 1);
        chk("tmo_cause", err_cause, 3);
        chk("tmo_level", level, 1);
        chk("tmo_busy", busy, 0);

        // Randomized traffic
        rand_ready = 1;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 65)
                send_frame($urandom_range(1, MAX_LEN), 0, $urandom_range(0, 2));
            else if (r < 78)
                send_frame($urandom_range(1, MAX_LEN), 1, 1);
            else if (r < 88) begin
                cyc(1, SYNC);
                cyc(1, ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(17, 255)));
            end else
                cyc(1, 8'($urandom));
            idle_n($urandom_range(0, 3));
        end
        rand_ready = 0;

        // Reset mid-payload with committed data present
        out_ready = 0;
        send_frame(3, 0, 0);
        cyc(1, 8'hA5); cyc(1, 8'h05); cyc(1, 8'h01); cyc(1, 8'h02);
        cyc(0, 0);
        chk("pre_rst_busy", busy, 1);
        #3 rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cause", err_cause, 0);
        chk("mid_rst_ok", frame_ok, 0);
        chk("mid_rst_err", frame_err, 0);
        @(negedge pi_clk);
        rst_n = 1'b0;
        out_ready = 1;
        dut_pops.delete();
        cyc(1, 8'hA5); cyc(1, 8'h01); cyc(1, 8'h3C); cyc(1, 8'h3D);
        idle_n(4);
        chk("post_rst_npops", dut_pops.size(), 1);
        if (dut_pops.size() == 1) chk("post_rst_b", dut_pops[0], 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pi_frame_rx.md
PI_FRAME_RX -- requirements
Module: pi_frame_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 32: payload FIFO depth in bytes, power of two, at least 16.
REQ-002 SHALL have parameter MAX_LEN, default 16: largest legal frame payload length, at most DEPTH.
REQ-003 SHALL have parameter SYNC, default 8'hA5: frame start byte.
REQ-004 SHALL have parameter TIMEOUT, default 1024: idle pi_clk cycles allowed inside a frame.
REQ-005 SHALL have port pi_clk, input, 1 bit: clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port gpio_data, input, 8 bits: byte from the Pi GPIO bus.
REQ-008 SHALL have port gpio_valid, input, 1 bit: gpio_data holds a new byte; sampled each edge.
REQ-009 SHALL have port out_data, output, 8 bits: FIFO head byte; 0 when out_valid is low.
REQ-010 SHALL have port out_valid, output, 1 bit: at least one committed byte is available.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the head byte.
REQ-012 SHALL have port level, output, clog2(DEPTH)+1 bits: committed bytes not yet read.
REQ-013 SHALL have port frame_ok, output, 1 bit: one-cycle pulse when a frame is committed.
REQ-014 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is dropped.
REQ-015 SHALL have port err_cause, output, 2 bits: cause of the last drop (0 chk, 1 len, 2 ovf, 3 timeout); holds until the next drop.
REQ-016 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 SHALL accept a byte only on an edge where gpio_valid=1; edges with gpio_valid=0 SHALL NOT change the parser state.
REQ-018 SHALL parse frames as SYNC, LEN, LEN payload bytes, CHK, where CHK = LEN XOR every payload byte.
REQ-019 SHALL implement the states IDLE, GETLEN, PAYLOAD, GETCHK and DISCARD.
REQ-020 SHALL stay in IDLE on a non-SYNC byte and SHALL move to GETLEN on a SYNC byte.
REQ-021 SHALL, in GETLEN, drop the frame on LEN=0 or LEN>MAX_LEN (cause 1, frame_err) and return to IDLE.
REQ-022 SHALL, in GETLEN, drop the frame on LEN greater than the free space (cause 2, frame_err) and enter DISCARD to swallow LEN+1 further bytes before IDLE; free space is DEPTH-level using level before any same-edge pop.
REQ-023 SHALL otherwise enter PAYLOAD, write each payload byte at a speculative write pointer, then enter GETCHK after LEN bytes.
REQ-024 SHALL, in GETCHK on a checksum match, set the commit pointer to the speculative pointer on the same edge and pulse frame_ok in the following cycle.
REQ-025 SHALL, in GETCHK on a checksum mismatch, roll the speculative pointer back to the commit pointer and pulse frame_err with cause 0.
REQ-026 SHALL return to IDLE from GETCHK after either outcome.
REQ-027 SHALL make uncommitted bytes invisible to out_valid, out_data and level.
REQ-028 SHALL reset an idle counter on every accepted byte and count every other cycle in GETLEN, PAYLOAD, GETCHK and DISCARD.
REQ-029 SHALL, when the idle counter reaches TIMEOUT, roll back, pulse frame_err with cause 3 and go to IDLE.
REQ-030 SHALL pop one byte on any edge with out_valid=1 and out_ready=1, advancing the read pointer modulo DEPTH.
REQ-031 SHALL drive out_data combinationally from the head entry (show-ahead).
REQ-032 SHALL, on a pop and a commit in the same edge, update level to level - 1 + LEN.
REQ-033 SHALL wrap all pointers modulo DEPTH, with one extra bit used to tell full from empty.
REQ-034 SHALL treat out_ready=1 with out_valid=0 as a no-op.

Reset
REQ-035 SHALL, while rst_n=1, immediately force state IDLE, all pointers and counters to 0, and out_valid, level, frame_ok, frame_err, err_cause and busy to 0.
REQ-036 SHALL discard any partial frame and all committed data on reset mid-frame; FIFO RAM contents need not be cleared.

Verification
REQ-037 SHALL verify a good frame: A5 03 01 02 03 03 with out_ready=1 -> frame_ok pulse once, out_data 01,02,03 in order, level ends 0.
REQ-038 SHALL verify a checksum error: A5 02 10 20 00 -> frame_err, err_cause=0, out_valid stays 0, and a following good frame is delivered intact.
REQ-039 SHALL verify length errors: A5 00 and A5 11 (with MAX_LEN=16) -> frame_err with cause 1, busy low on the next cycle.
REQ-040 SHALL verify overflow: out_ready=0, two 16-byte frames then A5 01 ... -> third frame gives cause 2, level=32, and the next frame after the DISCARD bytes parses normally.
REQ-041 SHALL verify timeout: A5 04 AA, then gpio_valid=0 for 1024 cycles -> frame_err with cause 3, level unchanged.
REQ-042 SHALL verify simultaneous and reset cases: pop on the same edge as a commit gives the level math of REQ-032 and pointer wrap past 31; rst_n pulse mid-PAYLOAD gives all outputs 0 at once.
